// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle arithmetic/logic ops plus an iterative
// 1-bit-per-cycle shifter, with registered result and flags.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             sign,
    output logic             ovf,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               sign_q, sign_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic               load;

    logic [SHW-1:0]     shamt;
    logic               is_shift;
    logic [WIDTH-1:0]   add_a, add_b;
    logic               add_cin;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry, alu_ovf, alu_err;
    logic [WIDTH-1:0]   step_res;
    logic               step_bit;

    assign shamt    = b[SHW-1:0];
    assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    assign in_ready = (state_q == IDLE) && !rst;

    // One shared adder serves ADD, SUB (a + ~b + 1) and NEG (0 + ~b + 1).
    always_comb begin
        add_a   = a;
        add_b   = b;
        add_cin = 1'b0;
        if (op == OP_SUB) begin
            add_b   = ~b;
            add_cin = 1'b1;
        end else if (op == OP_NEG) begin
            add_a   = '0;
            add_b   = ~b;
            add_cin = 1'b1;
        end
    end

    assign sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (op)
            OP_PASS: alu_res = a;
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_XOR: alu_res = a ^ b;
            OP_OR:  alu_res = a | b;
            OP_NEG: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (b == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_SLL, OP_SRL, OP_SRA: alu_res = a;  // only reached with shamt == 0
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_SLL: begin
                step_res = {sreg_q[WIDTH-2:0], 1'b0};
                step_bit = sreg_q[WIDTH-1];
            end
            OP_SRA: begin
                step_res = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
                step_bit = sreg_q[0];
            end
            default: begin
                step_res = {1'b0, sreg_q[WIDTH-1:1]};
                step_bit = sreg_q[0];
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        zero_d   = zero_q;
        sign_d   = sign_q;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift && (shamt != '0)) begin
                        op_d    = op;
                        sreg_d  = a;
                        cnt_d   = shamt;
                        state_d = SHIFT;
                    end else begin
                        result_d = alu_res;
                        carry_d  = alu_carry;
                        ovf_d    = alu_ovf;
                        err_d    = alu_err;
                        load     = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                sreg_d = step_res;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    result_d = step_res;
                    carry_d  = step_bit;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    load     = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            zero_d = (result_d == '0);
            sign_d = result_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sreg_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            sign_q   <= sign_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign sign      = sign_q;
    assign ovf       = ovf_q;
    assign err       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, handshake/reset
// corner sequences, and randomized ops against an arithmetic reference model.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry, zero, sign, ovf, err;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero), .sign(sign),
        .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        c, z, s, v, e;
        int          lat;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operands, signed range checks for overflow.
    function automatic vec_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        vec_t   m;
        longint s;
        int     sh;
        sh = int'(y[4:0]);
        m.op = o; m.a = x; m.b = y;
        m.r = '0; m.c = 0; m.v = 0; m.e = 0; m.lat = 1;
        case (o)
            4'h0: m.r = x;
            4'h1: begin
                m.r = x + y;
                m.c = ({32'd0, x} + {32'd0, y}) > 64'hFFFF_FFFF;
                s   = longint'($signed(x)) + longint'($signed(y));
                m.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h2: begin
                m.r = x - y;
                m.c = (x >= y);
                s   = longint'($signed(x)) - longint'($signed(y));
                m.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h3: m.r = x & y;
            4'h4: m.r = x ^ y;
            4'h5: m.r = x | y;
            4'h6: begin
                m.r = 32'd0 - y;
                m.c = (y == 32'd0);
                s   = -longint'($signed(y));
                m.v = (s > 64'sd2147483647);
            end
            4'h8, 4'h9, 4'hA: begin
                if (o == 4'h8)      m.r = x << sh;
                else if (o == 4'h9) m.r = x >> sh;
                else                m.r = $signed(x) >>> sh;
                if (sh > 0) begin
                    m.c   = (o == 4'h8) ? x[32-sh] : x[sh-1];
                    m.lat = sh + 1;
                end
            end
            default: m.e = 1;
        endcase
        m.z = (m.r == 32'd0);
        m.s = m.r[31];
        return m;
    endfunction

    // Called at posedge+1; accepts one op, waits for out_valid, returns observed fields.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          output vec_t got);
        int lat;
        op = o; a = x; b = y; in_valid = 1'b1;
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        got.op = o; got.a = x; got.b = y;
        got.r = result; got.c = carry; got.z = zero; got.s = sign;
        got.v = ovf; got.e = err; got.lat = lat;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic compare(input string tag, input vec_t got, input vec_t exp);
        chk({tag, ".result"},  got.r, exp.r);
        chk({tag, ".carry"},   32'(got.c), 32'(exp.c));
        chk({tag, ".zero"},    32'(got.z), 32'(exp.z));
        chk({tag, ".sign"},    32'(got.s), 32'(exp.s));
        chk({tag, ".ovf"},     32'(got.v), 32'(exp.v));
        chk({tag, ".err"},     32'(got.e), 32'(exp.e));
        chk({tag, ".latency"}, 32'(got.lat), 32'(exp.lat));
        $display("op=%h a=%h b=%h -> result=%h c=%0b z=%0b s=%0b v=%0b e=%0b lat=%0d",
                 got.op, got.a, got.b, got.r, got.c, got.z, got.s, got.v, got.e, got.lat);
    endtask

    vec_t tbl[15];
    vec_t got, exp_v;
    int   seen;

    initial begin
        //           op     a             b             r             c  z  s  v  e  lat
        tbl[0]  = '{4'h1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0, 0, 0, 1};
        tbl[1]  = '{4'h2, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0, 0, 1, 0, 0, 1};
        tbl[2]  = '{4'h2, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 0, 0, 1, 0, 1};
        tbl[3]  = '{4'hA, 32'h80000000, 32'h00000004, 32'hF8000000, 0, 0, 1, 0, 0, 5};
        tbl[4]  = '{4'h8, 32'h80000001, 32'h00000001, 32'h00000002, 1, 0, 0, 0, 0, 2};
        tbl[5]  = '{4'hF, 32'h00000003, 32'h00000004, 32'h00000000, 0, 1, 0, 0, 1, 1};
        tbl[6]  = '{4'h0, 32'h00000009, 32'h00000000, 32'h00000009, 0, 0, 0, 0, 0, 1};
        tbl[7]  = '{4'h6, 32'h12345678, 32'h00000000, 32'h00000000, 1, 1, 0, 0, 0, 1};
        tbl[8]  = '{4'h6, 32'h00000000, 32'h80000000, 32'h80000000, 0, 0, 1, 1, 0, 1};
        tbl[9]  = '{4'h5, 32'h000000F0, 32'h0000000F, 32'h000000FF, 0, 0, 0, 0, 0, 1};
        tbl[10] = '{4'h4, 32'h000000FF, 32'h0000000F, 32'h000000F0, 0, 0, 0, 0, 0, 1};
        tbl[11] = '{4'h9, 32'hFFFFFFFF, 32'h0000001F, 32'h00000001, 1, 0, 0, 0, 0, 32};
        tbl[12] = '{4'h8, 32'h00001234, 32'h00000020, 32'h00001234, 0, 0, 0, 0, 0, 1};
        tbl[13] = '{4'h1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 1, 0, 1};
        tbl[14] = '{4'h7, 32'h00000005, 32'h00000006, 32'h00000000, 0, 1, 0, 0, 1, 1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.in_ready_during_rst", 32'(in_ready), 32'd0);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.result", result, 32'd0);
        chk("reset.flags", 32'({carry, zero, sign, ovf, err}), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset.in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 15; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, got);
            compare($sformatf("vec%0d", i), got, tbl[i]);
        end

        // Backpressure: AND completes while consumer stalls; a new op waits
        out_ready = 1'b0;
        op = 4'h3; a = 32'h0000F0F0; b = 32'h0000FF00; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 4'h4; a = 32'h00000001; b = 32'h00000002;
        for (int i = 0; i < 3; i++) begin
            chk("bp.out_valid", 32'(out_valid), 32'd1);
            chk("bp.result", result, 32'h0000F000);
            chk("bp.flags", 32'({carry, zero, sign, ovf, err}), 32'd0);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.out_valid_drop", 32'(out_valid), 32'd0);
        chk("bp.in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.new_op_valid", 32'(out_valid), 32'd1);
        chk("bp.new_op_result", result, 32'h00000003);
        $display("backpressure AND then XOR -> result=%h", result);
        @(posedge clk); #1;

        // Reset in the middle of a 20-bit shift: nothing may ever come out
        op = 4'h8; a = 32'h00000001; b = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort.in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort.out_valid", 32'(out_valid), 32'd0);
        chk("abort.result", result, 32'd0);
        chk("abort.flags", 32'({carry, zero, sign, ovf, err}), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort.no_emit", 32'(seen), 32'd0);
        $display("mid-shift reset -> out_valid cycles seen afterwards=%0d", seen);

        // Randomized ops against the reference model
        for (int i = 0; i < 200; i++) begin
            logic [3:0]  ro;
            logic [31:0] ra, rb;
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h80000000;
                1: rb = 32'h80000000;
                2: rb = 32'h0;
                3: ra = 32'hFFFFFFFF;
                default: ;
            endcase
            exp_v = model(ro, ra, rb);
            run_op(ro, ra, rb, got);
            compare($sformatf("rnd%0d", i), got, exp_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
